// File: rtl/instr_sequencer_if.sv
// Sequencer bus interface: groups the program-ROM read port and the
// processor run/din/done handshake into one bundle.
//   mem_addr  : registered ROM address (sequencer -> ROM)
//   mem_rdata : ROM word, valid one cycle after mem_addr (ROM -> sequencer)
//   proc_din  : word presented on the processor din (sequencer -> processor)
//   proc_run  : one-cycle run pulse (sequencer -> processor)
//   proc_done : instruction complete (processor -> sequencer)
// master = sequencer side, slave = ROM/processor side.
interface instr_sequencer_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 9
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] proc_din;
  logic              proc_run;
  logic              proc_done;

  modport master (
    output mem_addr, proc_din, proc_run,
    input  mem_rdata, proc_done
  );

  modport slave (
    input  mem_addr, proc_din, proc_run,
    output mem_rdata, proc_done
  );
endinterface

// File: rtl/instr_sequencer.sv
// Program sequencer for the base processor. Fetches 9-bit words from a
// synchronous ROM, issues each instruction on proc_din with a one-cycle
// proc_run pulse, supplies the immediate word of mvi in the following
// cycle, then waits for proc_done before fetching the next instruction.
// Ports:
//   clk, resetn : clock (rising edge), asynchronous active-low reset
//   start       : begin program at address 0 (sampled only in IDLE)
//   halt_req    : stop at the next instruction boundary
//   bus         : ROM read port + processor handshake (master modport)
//   busy        : high in every state except IDLE
//   prog_done   : one-cycle pulse on normal completion
//   err         : sticky fault (mvi on last word, or done timeout)
//   instr_cnt   : completed instructions, saturating at 255
module instr_sequencer #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 9,
  parameter int PROG_LEN = 32,
  parameter int TMO_CYC  = 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic                halt_req,
  instr_sequencer_if.master   bus,
  output logic                busy,
  output logic                prog_done,
  output logic                err,
  output logic [7:0]          instr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_IMM,
    S_WAIT
  } state_t;

  localparam int              WD_W    = $clog2(TMO_CYC + 1);
  localparam logic [2:0]      OP_MVI  = 3'b001;
  // pc carries one extra bit so pc >= PROG_LEN is visible even when
  // PROG_LEN equals 2**ADDR_W.
  localparam logic [ADDR_W:0] PC_LAST = (ADDR_W+1)'(PROG_LEN - 1);
  localparam logic [ADDR_W:0] PC_END  = (ADDR_W+1)'(PROG_LEN);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TMO_CYC - 1);

  state_t            state, state_nx;
  logic [ADDR_W:0]   pc, pc_nx, pc_inc, pc_inc2;
  logic [ADDR_W-1:0] addr_nx;
  logic [WD_W-1:0]   wd, wd_nx;
  logic [7:0]        cnt_nx;
  logic              err_nx, prog_done_nx;
  logic              is_mvi;

  assign is_mvi  = (bus.mem_rdata[DATA_W-1 -: 3] == OP_MVI);
  assign pc_inc  = pc + 1'b1;
  assign pc_inc2 = pc + 2'd2;
  assign busy    = (state != S_IDLE);

  // The ROM word is only meaningful to the processor while an instruction
  // or its immediate is being handed over.
  assign bus.proc_din = (state == S_ISSUE || state == S_IMM) ? bus.mem_rdata : '0;

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx     = state;
    pc_nx        = pc;
    addr_nx      = bus.mem_addr;
    wd_nx        = wd;
    cnt_nx       = instr_cnt;
    err_nx       = err;
    prog_done_nx = 1'b0;
    bus.proc_run = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          pc_nx    = '0;
          addr_nx  = '0;
          err_nx   = 1'b0;
          cnt_nx   = '0;
          state_nx = S_FETCH;
        end
      end

      S_FETCH: begin
        // ROM is reading pc now; prefetch pc+1 so an mvi immediate is ready.
        addr_nx  = pc_inc[ADDR_W-1:0];
        state_nx = S_ISSUE;
      end

      S_ISSUE: begin
        wd_nx = '0;
        if (is_mvi && pc == PC_LAST) begin
          // Immediate word would lie beyond the program: never issue it.
          err_nx   = 1'b1;
          state_nx = S_IDLE;
        end else begin
          bus.proc_run = 1'b1;
          if (is_mvi) begin
            state_nx = S_IMM;
          end else begin
            pc_nx    = pc_inc;
            state_nx = S_WAIT;
          end
        end
      end

      S_IMM: begin
        pc_nx    = pc_inc2;
        state_nx = S_WAIT;
      end

      S_WAIT: begin
        // done takes priority over a timeout in the same cycle.
        if (bus.proc_done) begin
          if (instr_cnt != 8'hFF) cnt_nx = instr_cnt + 8'd1;
          if (halt_req || pc >= PC_END) begin
            prog_done_nx = 1'b1;
            state_nx     = S_IDLE;
          end else begin
            addr_nx  = pc[ADDR_W-1:0];
            state_nx = S_FETCH;
          end
        end else if (wd == WD_LAST) begin
          err_nx   = 1'b1;
          state_nx = S_IDLE;
        end else begin
          wd_nx = wd + 1'b1;
        end
      end

      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      pc           <= '0;
      bus.mem_addr <= '0;
      wd           <= '0;
      instr_cnt    <= '0;
      err          <= 1'b0;
      prog_done    <= 1'b0;
    end else begin
      state        <= state_nx;
      pc           <= pc_nx;
      bus.mem_addr <= addr_nx;
      wd           <= wd_nx;
      instr_cnt    <= cnt_nx;
      err          <= err_nx;
      prog_done    <= prog_done_nx;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed testbench for instr_sequencer. dut runs a 5-word program
// (PROG_LEN=5) against a ROM model and a processor model that returns done
// 1-3 cycles after each run pulse; dut1 (PROG_LEN=1) holds a lone mvi.
module tb_instr_sequencer;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 9;
  localparam int TMO_CYC = 8;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0, halt_req = 1'b0, start1 = 1'b0;
  logic       busy, prog_done, err, busy1, prog_done1, err1;
  logic [7:0] instr_cnt, instr_cnt1;
  int         checks = 0, errors = 0;
  bit         proc_en = 1'b1;

  always #5 clk = ~clk;

  instr_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  instr_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();

  instr_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PROG_LEN(5), .TMO_CYC(TMO_CYC)) dut (
    .clk(clk), .resetn(resetn), .start(start), .halt_req(halt_req), .bus(bus),
    .busy(busy), .prog_done(prog_done), .err(err), .instr_cnt(instr_cnt));

  instr_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PROG_LEN(1), .TMO_CYC(TMO_CYC)) dut1 (
    .clk(clk), .resetn(resetn), .start(start1), .halt_req(1'b0), .bus(bus1),
    .busy(busy1), .prog_done(prog_done1), .err(err1), .instr_cnt(instr_cnt1));

  // ROM models: synchronous read, one cycle latency.
  function automatic logic [8:0] rom_word(input logic [ADDR_W-1:0] a);
    case (a)
      5'd0:    return 9'h010;
      5'd1:    return 9'h048;
      5'd2:    return 9'h05A;
      5'd3:    return 9'h093;
      5'd4:    return 9'h0E5;
      default: return 9'h000;
    endcase
  endfunction

  always @(posedge clk) bus.mem_rdata <= rom_word(bus.mem_addr);
  always @(posedge clk) bus1.mem_rdata <= (bus1.mem_addr == '0) ? 9'h048 : 9'h000;
  assign bus1.proc_done = 1'b0;

  // Processor model: done after 3 cycles for mvi, else 1..3 cycles.
  bit pm_pend = 1'b0;
  int pm_cnt = 0, pm_idx = 0;
  always @(negedge clk or negedge resetn) begin
    if (!resetn) begin
      pm_pend = 1'b0;
      pm_cnt = 0;
      bus.proc_done = 1'b0;
    end else begin
      bus.proc_done = 1'b0;
      if (pm_pend) begin
        if (pm_cnt <= 1) begin
          bus.proc_done = 1'b1;
          pm_pend = 1'b0;
        end else pm_cnt--;
      end
      if (proc_en && bus.proc_run) begin
        pm_pend = 1'b1;
        pm_cnt = (bus.proc_din[8:6] == 3'b001) ? 3 : 1 + (pm_idx % 3);
        pm_idx++;
      end
    end
  end

  // Monitor: cumulative event counts; tests compare deltas.
  int         run_total = 0, imm_total = 0, pd_total = 0, addr_hi_total = 0, run1_total = 0;
  logic [8:0] run_din [0:63];
  logic [8:0] imm_din = '0;
  bit         prev_mvi = 1'b0;
  always @(negedge clk) begin
    if (bus.proc_run === 1'b1) begin
      if (run_total < 64) run_din[run_total] = bus.proc_din;
      run_total++;
    end
    if (prev_mvi) begin
      imm_din = bus.proc_din;
      imm_total++;
    end
    prev_mvi = (bus.proc_run === 1'b1) && (bus.proc_din[8:6] == 3'b001);
    if (prog_done === 1'b1) pd_total++;
    if (bus.mem_addr >= 5'd2) addr_hi_total++;
    if (bus1.proc_run === 1'b1) run1_total++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: busy=%b after %0d cycles, required 0", name, busy, n);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    start = 1'b1;
    step();
    step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_hold_busy: got %b want 0", busy); end
    start = 1'b0;
    resetn = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++;
    if (prog_done !== 1'b0) begin errors++; $display("FAIL reset_prog_done: got %b want 0", prog_done); end
    checks++;
    if (instr_cnt !== 8'd0) begin errors++; $display("FAIL reset_instr_cnt: got %0d want 0", instr_cnt); end
    checks++;
    if (bus.proc_run !== 1'b0) begin errors++; $display("FAIL reset_proc_run: got %b want 0", bus.proc_run); end
    checks++;
    if (bus.mem_addr !== 5'd0) begin errors++; $display("FAIL reset_mem_addr: got %0d want 0", bus.mem_addr); end
    checks++;
    if (bus.proc_din !== 9'd0) begin errors++; $display("FAIL reset_proc_din: got %h want 000", bus.proc_din); end
  endtask

  task automatic test_program();
    logic [8:0] exp_din [4] = '{9'h010, 9'h048, 9'h093, 9'h0E5};
    int r0 = run_total, i0 = imm_total, p0 = pd_total;
    pulse_start();
    // FETCH cycle: busy, no run yet
    checks++;
    if (busy !== 1'b1 || bus.proc_run !== 1'b0) begin
      errors++; $display("FAIL prog_fetch: busy=%b run=%b want 1/0", busy, bus.proc_run);
    end
    step();
    checks++;
    if (bus.proc_run !== 1'b1 || bus.proc_din !== 9'h010) begin
      errors++; $display("FAIL prog_latency: run=%b din=%h want 1/010", bus.proc_run, bus.proc_din);
    end
    wait_idle(100, "prog");
    step();
    checks++;
    if (run_total - r0 != 4) begin errors++; $display("FAIL prog_runs: got %0d want 4", run_total - r0); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (run_din[r0+k] !== exp_din[k]) begin
        errors++; $display("FAIL prog_din%0d: got %h want %h", k, run_din[r0+k], exp_din[k]);
      end
    end
    checks++;
    if (imm_total - i0 != 1 || imm_din !== 9'h05A) begin
      errors++; $display("FAIL prog_imm: count=%0d din=%h want 1/05a", imm_total - i0, imm_din);
    end
    checks++;
    if (instr_cnt !== 8'd4) begin errors++; $display("FAIL prog_instr_cnt: got %0d want 4", instr_cnt); end
    checks++;
    if (pd_total - p0 != 1) begin errors++; $display("FAIL prog_done_pulses: got %0d want 1", pd_total - p0); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL prog_err: got %b want 0", err); end
  endtask

  task automatic test_halt();
    int r0 = run_total, p0 = pd_total, a0;
    halt_req = 1'b1;
    pulse_start();
    a0 = addr_hi_total;
    wait_idle(50, "halt");
    step();
    halt_req = 1'b0;
    checks++;
    if (run_total - r0 != 1) begin errors++; $display("FAIL halt_runs: got %0d want 1", run_total - r0); end
    checks++;
    if (pd_total - p0 != 1) begin errors++; $display("FAIL halt_prog_done: got %0d want 1", pd_total - p0); end
    checks++;
    if (addr_hi_total - a0 != 0) begin
      errors++; $display("FAIL halt_mem_addr: %0d cycles with mem_addr>=2, want 0", addr_hi_total - a0);
    end
    checks++;
    if (instr_cnt !== 8'd1) begin errors++; $display("FAIL halt_instr_cnt: got %0d want 1", instr_cnt); end
  endtask

  task automatic test_watchdog();
    int r0 = run_total, p0 = pd_total, n = 0;
    proc_en = 1'b0;
    pulse_start();
    while (run_total == r0 && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (run_total == r0) begin errors++; $display("FAIL wdog_run: no run pulse within 10 cycles"); end
    // err registers on the 8th edge after the edge that sampled run.
    for (int k = 1; k <= TMO_CYC + 1; k++) begin
      step();
      checks++;
      if (err !== (k == TMO_CYC + 1)) begin
        errors++; $display("FAIL wdog_err_k%0d: got %b want %b", k, err, (k == TMO_CYC + 1));
      end
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL wdog_busy: got %b want 0", busy); end
    checks++;
    if (pd_total - p0 != 0) begin errors++; $display("FAIL wdog_prog_done: got %0d want 0", pd_total - p0); end
    proc_en = 1'b1;
    pulse_start();
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL wdog_clear: got %b want 0", err); end
    wait_idle(100, "wdog_rerun");
    checks++;
    if (instr_cnt !== 8'd4) begin errors++; $display("FAIL wdog_rerun_cnt: got %0d want 4", instr_cnt); end
  endtask

  task automatic test_mvi_last();
    int r0 = run1_total;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    checks++;
    if (busy1 !== 1'b1) begin errors++; $display("FAIL mvi_last_busy_fetch: got %b want 1", busy1); end
    step();
    checks++;
    if (busy1 !== 1'b1 || bus1.proc_run !== 1'b0) begin
      errors++; $display("FAIL mvi_last_issue: busy=%b run=%b want 1/0", busy1, bus1.proc_run);
    end
    step();
    checks++;
    if (busy1 !== 1'b0 || err1 !== 1'b1) begin
      errors++; $display("FAIL mvi_last_end: busy=%b err=%b want 0/1", busy1, err1);
    end
    checks++;
    if (run1_total != r0) begin errors++; $display("FAIL mvi_last_runs: got %0d want 0", run1_total - r0); end
  endtask

  task automatic test_mid_reset();
    int r0 = run_total, n = 0;
    pulse_start();
    while (run_total - r0 < 2 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (run_total - r0 < 2) begin errors++; $display("FAIL midrst_reach: only %0d runs", run_total - r0); end
    step();  // IMM
    step();  // WAIT, done not yet returned
    resetn = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || bus.proc_run !== 1'b0 || err !== 1'b0 || prog_done !== 1'b0) begin
      errors++; $display("FAIL midrst_ctrl: busy=%b run=%b err=%b pd=%b want 0", busy, bus.proc_run, err, prog_done);
    end
    checks++;
    if (bus.mem_addr !== 5'd0 || bus.proc_din !== 9'd0 || instr_cnt !== 8'd0) begin
      errors++; $display("FAIL midrst_data: addr=%0d din=%h cnt=%0d want 0", bus.mem_addr, bus.proc_din, instr_cnt);
    end
    step();
    step();
    resetn = 1'b1;
    step();
    r0 = run_total;
    pulse_start();
    n = 0;
    while (run_total == r0 && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (run_total == r0 || run_din[r0] !== 9'h010) begin
      errors++; $display("FAIL midrst_restart: first din=%h want 010", run_din[r0]);
    end
    wait_idle(100, "midrst");
    checks++;
    if (instr_cnt !== 8'd4) begin errors++; $display("FAIL midrst_cnt: got %0d want 4", instr_cnt); end
  endtask

  initial begin
    test_reset();
    test_program();
    test_halt();
    test_watchdog();
    test_mvi_last();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Program sequencer that feeds the base processor from a synchronous instruction ROM. It fetches 9-bit words, presents each instruction on the processor din with a one-cycle run pulse, and supplies the second word for mvi in the following cycle. It waits for done, then moves to the next instruction. It sits between the program ROM and the processor's run/din/done interface, replacing hand-driven run/ir stimulus.

Parameters:
ADDR_W, 5, ROM address width
DATA_W, 9, instruction/data word width (III_XXX_YYY)
PROG_LEN, 32, number of program words executed; must be at most 2**ADDR_W
TMO_CYC, 8, maximum cycles from run pulse to done before a fault is flagged

Ports:
clk  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
start  in  1  begin program at address 0; sampled only in IDLE
halt_req  in  1  stop at next instruction boundary
mem_addr  out  ADDR_W  registered ROM address
mem_rdata  in  DATA_W  ROM data, valid 1 cycle after mem_addr
proc_din  out  DATA_W  word to processor din
proc_run  out  1  run pulse to processor
proc_done  in  1  processor done
busy  out  1  high in every state except IDLE
prog_done  out  1  1-cycle pulse on normal completion
err  out  1  sticky fault flag
instr_cnt  out  8  completed instructions, saturating at 255

Behaviour:
- Reset (async, resetn=0): state=IDLE; pc=0; mem_addr=0; proc_run=0; prog_done=0; err=0; instr_cnt=0; watchdog=0. Reset mid-operation aborts at once, with no further run pulse.
- proc_din = mem_rdata in ISSUE and IMM; otherwise 0.
- opcode = mem_rdata[8:6]; mvi = 3'b001.
- FSM states:
  - IDLE: if start=1, then pc<=0, mem_addr<=0, err<=0, instr_cnt<=0, go to FETCH. start while busy is ignored.
  - FETCH (1 cycle): ROM reads pc; mem_addr<=pc+1; go to ISSUE.
  - ISSUE (1 cycle): mem_rdata=word[pc]; watchdog<=0.
    - If opcode=mvi and pc=PROG_LEN-1: proc_run stays 0, err<=1, go to IDLE.
    - Otherwise proc_run=1.
    - If mvi: go to IMM.
    - Else: pc<=pc+1, go to WAIT.
  - IMM (1 cycle): mem_rdata=word[pc+1], driven on proc_din to match the processor's T1 din_en. proc_run=0; pc<=pc+2; go to WAIT.
  - WAIT: proc_run=0; watchdog increments each cycle.
    - proc_done=1: instr_cnt<=instr_cnt+1 (saturating). If halt_req=1 or pc>=PROG_LEN, pulse prog_done and go to IDLE; otherwise mem_addr<=pc, go to FETCH.
    - watchdog reaches TMO_CYC without done: err<=1, go to IDLE, no prog_done.
- proc_done seen outside WAIT is ignored.
- halt_req is sampled only on the done cycle in WAIT and is otherwise ignored.
- If done coincides with the watchdog limit, done wins.
- Latency: start sampled at edge N puts proc_run=1 in cycle N+2. Per non-mvi instruction overhead is FETCH+ISSUE, i.e. 2 cycles plus processor time. Each mvi adds 1 cycle.
- pc is ADDR_W+1 bits so that pc>=PROG_LEN is detected when PROG_LEN=2**ADDR_W. mem_addr takes pc[ADDR_W-1:0].
- instr_cnt holds its value in IDLE until the next accepted start.

Test Plan:
- Reset then idle: resetn=0 for 2 cycles, release -> all outputs 0, busy=0. A start pulse while resetn=0 is ignored.
- 4-instruction program, PROG_LEN=5, ROM = {0x010 (mv R2,R0), 0x048 (mvi R1), 0x05A (imm), 0x093 (add R2,R3), 0x0E5 (sub R4,R5)}; processor model raises done 1–3 cycles after run:
  - exactly 4 run pulses, carrying proc_din 0x010, 0x048, 0x093, 0x0E5;
  - cycle after the 0x048 pulse shows proc_din=0x05A;
  - instr_cnt=4, single prog_done pulse, err=0.
- halt_req=1 held during the first instruction -> exactly one run pulse; prog_done pulses after its done; pc stays 1; mem_addr never reaches 2.
- Watchdog: processor model never asserts done -> err=1 exactly TMO_CYC=8 cycles after the run cycle, state IDLE, no prog_done. A later start clears err.
- mvi at last word: PROG_LEN=1, ROM[0]=0x048 -> proc_run never asserts, err=1, busy drops 2 cycles after start.
- Mid-run reset: assert resetn=0 in WAIT of instruction 2 -> outputs immediately 0. After release, start re-executes from address 0 (first proc_din=0x010).
